// File: rtl/asic_iopwrseq_pkg.sv
// Shared definitions for the IO-ring power sequencer: FSM state encoding
// and the depth of the power-good synchroniser.
package asic_iopwrseq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_UP_WAIT   = 3'd1,
        ST_UP_SETTLE = 3'd2,
        ST_ON        = 3'd3,
        ST_DN_SETTLE = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/asic_iopwrseq_dsync.sv
// Multi-bit flop-chain synchroniser for the asynchronous per-segment
// power-good inputs. Each bit is synchronised independently; all stages
// clear with the synchronous active-low reset.
module asic_dsync
    import asic_iopwrseq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [SYNC_DEPTH];

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[SYNC_DEPTH-1];

endmodule

// File: rtl/asic_iopwrseq.sv
// IO-ring power sequencer top level. Brings ring segments up one at a time
// (enable, wait for synchronised power-good, settle), powers them down in
// reverse order, and forces an all-off fault shutdown on power-good loss.
// Optional build macro ASIC_IOPWRSEQ_TIMEOUT_EN adds a power-good wait
// timeout that also leads to the fault state; without it the timeout port
// is ignored and UP_WAIT waits indefinitely.
module asic_iopwrseq
    import asic_iopwrseq_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  DW = 8,
    parameter int  TW = 12,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req,
    input  logic [DW-1:0] delay,
    input  logic [TW-1:0] timeout,
    input  logic [N-1:0]  pgood,
    output logic [N-1:0]  en,
    output logic          ready,
    output logic          busy,
    output logic          err,
    output logic [IW-1:0] idx
);

    state_t        state;
    logic [DW-1:0] cnt;
    logic [N-1:0]  pg_s;
    logic          tmo_hit;
    logic          fault_now;

    // A zero settle request still costs one cycle per step
    function automatic logic [DW-1:0] settle_load(input logic [DW-1:0] v);
        return (v == '0) ? DW'(1) : v;
    endfunction

    function automatic logic [N-1:0] seg_bit(input logic [IW-1:0] i);
        return N'(1) << i;
    endfunction

    asic_dsync #(.W(N)) u_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      (pgood),
        .q      (pg_s)
    );

`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_lim;

    // wait_cnt is 0 in the first UP_WAIT cycle, so matching lim-1 gives
    // exactly `timeout` cycles of waiting before the fault takes effect.
    assign tmo_hit = (wait_lim != '0) && (wait_cnt == wait_lim - 1'b1) && !pg_s[idx];
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout;
    assign tmo_hit        = 1'b0;
`endif

    // Only enabled segments are watched; disabled segments' pgood is ignored
    assign fault_now = ((state == ST_ON) && |(en & ~pg_s)) ||
                       ((state == ST_UP_WAIT) && tmo_hit);

    // Sequencer FSM with settle/wait counters and registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_OFF;
            en    <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
            wait_cnt <= '0;
            wait_lim <= '0;
`endif
        end else if (fault_now) begin
            // Fault wins over a simultaneous power-down request
            state <= ST_FAULT;
            en    <= '0;
            err   <= 1'b1;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (req) begin
                        state <= ST_UP_WAIT;
                        en    <= seg_bit(IW'(0));
                        idx   <= '0;
                        busy  <= 1'b1;
`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
                        wait_cnt <= '0;
                        wait_lim <= timeout;
`endif
                    end
                end

                ST_UP_WAIT: begin
`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                    if (!req) begin
                        state <= ST_DN_SETTLE;
                        en    <= en & ~seg_bit(idx);
                        cnt   <= settle_load(delay);
                    end else if (pg_s[idx]) begin
                        state <= ST_UP_SETTLE;
                        cnt   <= settle_load(delay);
                    end
                end

                ST_UP_SETTLE: begin
                    if (!req) begin
                        state <= ST_DN_SETTLE;
                        en    <= en & ~seg_bit(idx);
                        cnt   <= settle_load(delay);
                    end else if (cnt <= DW'(1)) begin
                        if (idx != IW'(N-1)) begin
                            state <= ST_UP_WAIT;
                            idx   <= idx + 1'b1;
                            en    <= en | seg_bit(idx + 1'b1);
`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
                            wait_cnt <= '0;
                            wait_lim <= timeout;
`endif
                        end else begin
                            state <= ST_ON;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_ON: begin
                    if (!req) begin
                        state <= ST_DN_SETTLE;
                        en    <= en & ~seg_bit(idx);
                        cnt   <= settle_load(delay);
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                ST_DN_SETTLE: begin
                    // req is deliberately ignored until OFF is reached
                    if (cnt <= DW'(1)) begin
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                            en  <= en & ~seg_bit(idx - 1'b1);
                            cnt <= settle_load(delay);
                        end else begin
                            state <= ST_OFF;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_FAULT: begin
                    if (!req) begin
                        state <= ST_OFF;
                        err   <= 1'b0;
                        idx   <= '0;
                    end
                end

                default: begin
                    state <= ST_OFF;
                    en    <= '0;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asic_iopwrseq.sv
// Testbench for asic_iopwrseq: scenario tasks driving req/delay/timeout and
// a pgood plant model (per-segment ramp after enable, optional forced loss).
// Expected waveforms come from the sequencing timeline computed arithmetically.
module tb_asic_iopwrseq;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TW = 12;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          nreset;
    logic          req;
    logic [DW-1:0] delay;
    logic [TW-1:0] timeout;
    logic [N-1:0]  pgood;
    logic [N-1:0]  en;
    logic          ready;
    logic          busy;
    logic          err;
    logic [IW-1:0] idx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ramp   [N];
    int on_cnt [N];
    logic [N-1:0] force_low;

    always #5 clk = ~clk;

    asic_iopwrseq #(.N(N), .DW(DW), .TW(TW)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .req     (req),
        .delay   (delay),
        .timeout (timeout),
        .pgood   (pgood),
        .en      (en),
        .ready   (ready),
        .busy    (busy),
        .err     (err),
        .idx     (idx)
    );

    function automatic int dmax(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Plant: a segment's supply reports good ramp[k] cycles after enable
    task automatic apply_pgood();
        for (int k = 0; k < N; k++)
            pgood[k] = en[k] && (on_cnt[k] > ramp[k]) && !force_low[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++)
            on_cnt[k] = en[k] ? on_cnt[k] + 1 : 0;
        apply_pgood();
    endtask

    task automatic do_reset();
        nreset    = 1'b0;
        req       = 1'b0;
        force_low = '0;
        timeout   = '0;
        for (int k = 0; k < N; k++) ramp[k] = 0;
        repeat (2) tick();
        nreset = 1'b1;
        tick();
    endtask

    // Timeline model of a full power-up from OFF
    task automatic power_up(input int dly);
        int rise [N];
        int t;
        int t_on;
        int exp_idx;
        logic [N-1:0] exp_en;
        logic exp_rdy, exp_busy;
        delay = DW'(dly);
        t = 1;
        for (int k = 0; k < N; k++) begin
            rise[k] = t;
            t += 3 + ramp[k] + dmax(dly);
        end
        t_on = t;
        req = 1'b1;
        cyc = 0;
        while (cyc < t_on + 1) begin
            tick();
            exp_idx = 0;
            for (int k = 0; k < N; k++) begin
                exp_en[k] = (cyc >= rise[k]);
                if (k > 0 && cyc >= rise[k]) exp_idx = k;
            end
            exp_rdy  = (cyc >= t_on);
            exp_busy = (cyc < t_on);
            vectors++;
            if (en !== exp_en || ready !== exp_rdy || busy !== exp_busy || err !== 1'b0 || idx !== IW'(exp_idx)) begin
                miscompares++;
                $display("FAIL power_up cyc=%0d en=%b ready=%b busy=%b err=%b idx=%0d required en=%b ready=%b busy=%b err=0 idx=%0d",
                         cyc, en, ready, busy, err, idx, exp_en, exp_rdy, exp_busy, exp_idx);
            end
        end
    endtask

    // Timeline model of power-down from ON; optional re-request mid-way
    task automatic power_down(input int dly, input int rereq);
        int t0;
        int d;
        int t_off;
        int exp_idx;
        logic [N-1:0] exp_en;
        logic exp_busy;
        d = dmax(dly);
        delay = DW'(dly);
        t0 = cyc;
        t_off = t0 + 1 + N * d;
        req = 1'b0;
        while (cyc < t_off) begin
            tick();
            for (int k = 0; k < N; k++)
                exp_en[k] = (cyc < t0 + 1 + (N - 1 - k) * d);
            exp_busy = (cyc < t_off);
            exp_idx  = (cyc < t_off) ? (N - 1 - (cyc - t0 - 1) / d) : 0;
            vectors++;
            if (en !== exp_en || busy !== exp_busy || ready !== 1'b0 || err !== 1'b0 || idx !== IW'(exp_idx)) begin
                miscompares++;
                $display("FAIL power_down cyc=%0d en=%b busy=%b ready=%b err=%b idx=%0d required en=%b busy=%b ready=0 err=0 idx=%0d",
                         cyc, en, busy, ready, err, idx, exp_en, exp_busy, exp_idx);
            end
            if (rereq >= 0 && cyc == t0 + rereq) req = 1'b1;
        end
        tick();
        exp_en   = (rereq >= 0) ? N'(1) : '0;
        exp_busy = (rereq >= 0);
        vectors++;
        if (en !== exp_en || busy !== exp_busy) begin
            miscompares++;
            $display("FAIL after_off cyc=%0d en=%b busy=%b required en=%b busy=%b", cyc, en, busy, exp_en, exp_busy);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; req = 1'b1; delay = 8'd3;
        repeat (2) tick();
        vectors++;
        if (en !== '0 || ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || idx !== '0) begin
            miscompares++;
            $display("FAIL reset_state en=%b ready=%b busy=%b err=%b idx=%0d required all 0", en, ready, busy, err, idx);
        end
        req = 1'b0; nreset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (en !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_off en=%b busy=%b required en=0 busy=0", en, busy);
        end
    endtask

    task automatic test_powerup();
        do_reset();
        power_up(3);
    endtask

    task automatic test_powerdown();
        power_down(3, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        power_up(2);
        power_down(2, 5);
        do_reset();
    endtask

    task automatic test_abort();
        int dly;
        int d;
        int c;
        int t_end;
        logic [N-1:0] exp_en;
        do_reset();
        dly = $urandom_range(0, 5);
        d = dmax(dly);
        delay = DW'(dly);
        c = 7 + d + $urandom_range(0, d - 1);
        req = 1'b1;
        cyc = 0;
        while (cyc < c) tick();
        vectors++;
        if (en !== 4'b0011 || idx !== 2'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre cyc=%0d en=%b idx=%0d busy=%b required en=0011 idx=1 busy=1", cyc, en, idx, busy);
        end
        req = 1'b0;
        t_end = c + 1 + 2 * d;
        while (cyc < t_end) begin
            tick();
            exp_en = '0;
            exp_en[0] = (cyc < c + 1 + d);
            vectors++;
            if (en !== exp_en || busy !== (cyc < t_end)) begin
                miscompares++;
                $display("FAIL abort cyc=%0d en=%b busy=%b required en=%b busy=%b", cyc, en, busy, exp_en, cyc < t_end);
            end
        end
        vectors++;
        if (idx !== '0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_end idx=%0d err=%b required idx=0 err=0", idx, err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        delay = 8'd3;
        timeout = 12'd10;
        force_low = 4'b0010;
        req = 1'b1;
        cyc = 0;
`ifdef ASIC_IOPWRSEQ_TIMEOUT_EN
        while (cyc < 17) begin
            tick();
            if (cyc >= 7 && cyc < 17) begin
                vectors++;
                if (en !== 4'b0011 || err !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tmo_wait cyc=%0d en=%b err=%b busy=%b required en=0011 err=0 busy=1", cyc, en, err, busy);
                end
            end
        end
        vectors++;
        if (en !== '0 || err !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_fault cyc=%0d en=%b err=%b busy=%b ready=%b required en=0 err=1 busy=0 ready=0", cyc, en, err, busy, ready);
        end
        req = 1'b0;
        tick();
        vectors++;
        if (err !== 1'b0 || idx !== '0 || en !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_exit err=%b idx=%0d en=%b busy=%b required all 0", err, idx, en, busy);
        end
`else
        while (cyc < 60) begin
            tick();
            if (cyc >= 7) begin
                vectors++;
                if (en !== 4'b0011 || err !== 1'b0 || busy !== 1'b1 || idx !== 2'd1) begin
                    miscompares++;
                    $display("FAIL wait_forever cyc=%0d en=%b err=%b busy=%b idx=%0d required en=0011 err=0 busy=1 idx=1", cyc, en, err, busy, idx);
                end
            end
        end
`endif
        do_reset();
    endtask

    // pgood[2] low for 3 cycles in ON; drop_req also lowers req as pg_s falls
    task automatic fault_scenario(input bit drop_req);
        int f;
        do_reset();
        power_up(1);
        tick();
        f = cyc;
        force_low = 4'b0100;
        apply_pgood();
        while (cyc < f + 3) begin
            if (drop_req && cyc == f + 2) req = 1'b0;
            tick();
            if (cyc == f + 3) begin
                force_low = '0;
                apply_pgood();
            end
            vectors++;
            if (cyc < f + 3) begin
                if (en !== 4'b1111 || err !== 1'b0 || ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pg_hold cyc=%0d en=%b err=%b ready=%b required en=1111 err=0 ready=1", cyc, en, err, ready);
                end
            end else if (en !== '0 || err !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL pg_fault cyc=%0d en=%b err=%b ready=%b busy=%b required en=0 err=1 ready=0 busy=0", cyc, en, err, ready, busy);
            end
        end
        if (!drop_req) begin
            repeat (3) begin
                tick();
                vectors++;
                if (err !== 1'b1 || en !== '0) begin
                    miscompares++;
                    $display("FAIL pg_latched cyc=%0d err=%b en=%b required err=1 en=0", cyc, err, en);
                end
            end
            req = 1'b0;
        end
        tick();
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0 || idx !== '0 || en !== '0) begin
            miscompares++;
            $display("FAIL fault_exit cyc=%0d err=%b busy=%b idx=%0d en=%b required all 0", cyc, err, busy, idx, en);
        end
    endtask

    task automatic test_pgood_loss();
        fault_scenario(1'b0);
    endtask

    task automatic test_fault_priority();
        fault_scenario(1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        delay = 8'd3;
        req = 1'b1;
        cyc = 0;
        while (cyc < 16) tick();
        vectors++;
        if (idx !== 2'd2 || en !== 4'b0111) begin
            miscompares++;
            $display("FAIL rstmid_pre idx=%0d en=%b required idx=2 en=0111", idx, en);
        end
        nreset = 1'b0;
        req = 1'b0;
        tick();
        vectors++;
        if (en !== '0 || ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || idx !== '0) begin
            miscompares++;
            $display("FAIL rstmid en=%b ready=%b busy=%b err=%b idx=%0d required all 0", en, ready, busy, err, idx);
        end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        repeat (6) begin
            for (int k = 0; k < N; k++) ramp[k] = $urandom_range(0, 3);
            power_up($urandom_range(0, 6));
            hold = $urandom_range(0, 4);
            repeat (hold) begin
                tick();
                vectors++;
                if (en !== 4'b1111 || ready !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL on_hold cyc=%0d en=%b ready=%b busy=%b required en=1111 ready=1 busy=0", cyc, en, ready, busy);
                end
            end
            power_down($urandom_range(0, 6), -1);
        end
    endtask

    initial begin
        nreset = 1'b0; req = 1'b0; delay = '0; timeout = '0;
        pgood = '0; force_low = '0;
        for (int k = 0; k < N; k++) begin
            ramp[k] = 0;
            on_cnt[k] = 0;
        end
        test_reset();
        test_powerup();
        test_powerdown();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_pgood_loss();
        test_fault_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
